seq_divider_4bit: RTL

SEQ_DIVIDER_4BIT -- requirements
Module: seq_divider_4bit

---
 rtl/seq_divider_4bit_if.sv | 30 +++
 rtl/seq_divider_4bit.sv | 128 ++++++++++++
 2 files changed

// File: rtl/seq_divider_4bit_if.sv
// Handshake and data bundle for the 4-bit sequential divider.
//   start        : request to begin a division (requester -> divider)
//   dividend     : 4-bit unsigned dividend     (requester -> divider)
//   divisor      : 4-bit unsigned divisor      (requester -> divider)
//   quotient     : 4-bit unsigned quotient     (divider -> requester)
//   remainder    : 4-bit unsigned remainder    (divider -> requester)
//   busy         : division in progress        (divider -> requester)
//   done         : one-cycle result-valid pulse (divider -> requester)
//   div_by_zero  : sampled divisor was zero, valid with done
// master = requester side, slave = divider side.
interface seq_divider_4bit_if;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/seq_divider_4bit.sv
// 4-bit unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : seq_divider_4bit_if.slave (start/dividend/divisor in,
//            quotient/remainder/busy/done/div_by_zero out, all registered)
// Flow: IDLE accepts start and latches operands; RUN performs four
// restoring steps; DONE pulses done for one cycle and returns to IDLE.
// A zero divisor skips RUN and reports quotient=15, remainder=dividend.
module seq_divider_4bit (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_divider_4bit_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_r;
    logic [3:0] divisor_r;
    // Partial remainder is kept in 4 bits: after each restoring step it is
    // always below the divisor, so the fifth bit only exists transiently
    // in shift_s.
    logic [3:0] rem_r;
    logic [3:0] q_r;
    logic [1:0] cnt_r;
    logic [3:0] quotient_r;
    logic [3:0] remainder_r;
    logic       busy_r;
    logic       done_r;
    logic       dbz_r;

    logic [4:0] shift_s;
    logic [3:0] rem_next_s;
    logic [3:0] q_next_s;

    // One restoring step: shift the next dividend bit into R, subtract if it fits.
    always_comb begin
        shift_s    = {rem_r, q_r[3]};
        rem_next_s = shift_s[3:0];
        q_next_s   = {q_r[2:0], 1'b0};
        if (shift_s >= {1'b0, divisor_r}) begin
            // True difference is below 16, so modulo-16 subtraction is exact.
            rem_next_s = shift_s[3:0] - divisor_r;
            q_next_s   = {q_r[2:0], 1'b1};
        end else begin
            rem_next_s = shift_s[3:0];
            q_next_s   = {q_r[2:0], 1'b0};
        end
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            divisor_r   <= 4'd0;
            rem_r       <= 4'd0;
            q_r         <= 4'd0;
            cnt_r       <= 2'd0;
            quotient_r  <= 4'd0;
            remainder_r <= 4'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    if (bus.start) begin
                        if (bus.divisor == 4'd0) begin
                            quotient_r  <= 4'hF;
                            remainder_r <= bus.dividend;
                            dbz_r       <= 1'b1;
                            done_r      <= 1'b1;
                            state_r     <= ST_DONE;
                        end else begin
                            divisor_r <= bus.divisor;
                            q_r       <= bus.dividend;
                            rem_r     <= 4'd0;
                            cnt_r     <= 2'd0;
                            busy_r    <= 1'b1;
                            state_r   <= ST_RUN;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    rem_r <= rem_next_s;
                    q_r   <= q_next_s;
                    if (cnt_r == 2'd3) begin
                        quotient_r  <= q_next_s;
                        remainder_r <= rem_next_s;
                        dbz_r       <= 1'b0;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + 2'd1;
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    // start is ignored here; always return to IDLE.
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;

endmodule
